ovf_exception_unit: RTL and testbench
=====================================

# ovf_exception_unit

Consumer end of the EX-stage overflow flags in the dual-issue pipeline. Samples both issue slots' overflow and trap-enable indications each cycle and squashes the faulting and younger instructions. Records EPC/cause and steers the front end to the exception vector through a valid/ready redirect handshake, then back to EPC on `eret`. Sits beside the EX stage; its outputs feed the writeback kill logic and the PC-select path.

## Interface
- `EXC_VECTOR`, 32'h0000_0080, handler entry PC
- `CNT_W`, 16, width of taken-exception counter
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ex_valid0`, `ex_valid1`  in  1  slot 0 / slot 1 holds a real instruction in EX; slot 0 is older
- `ex_ovf0`, `ex_ovf1`  in  1  slot overflow flag from its ALU
- `ex_trap_en0`, `ex_trap_en1`  in  1  slot instruction is a trapping signed add/sub; the overflow flag is garbage for other ops
- `ex_pc0`, `ex_pc1`  in  32  slot PC
- `eret`  in  1  return-from-exception pulse, valid in EX
- `redirect_ready`  in  1  front end accepts the redirect
- `kill0`, `kill1`  out  1  suppress that slot's writeback this cycle (combinational)
- `flush`  out  1  flush IF/ID and ID/EX this cycle (combinational)
- `busy`  out  1  state != IDLE; front end stalls fetch
- `redirect_valid`  out  1  redirect PC is presented
- `redirect_pc`  out  32  target PC
- `epc`  out  32  faulting instruction PC
- `cause_code`  out  5  5'd12 (arithmetic overflow) once an exception is taken
- `cause_slot`  out  1  slot that faulted
- `exl`  out  1  exception level; masks further traps
- `exc_count`  out  CNT_W  taken exceptions, saturating

## Operation
- `trapN = ex_validN & ex_trap_enN & ex_ovfN`. Traps are considered only in IDLE.
- States:
  - **IDLE**
    - `trap0`: capture `epc=ex_pc0`, `cause_slot=0`, `cause_code=12`, `exl=1`. Assert `kill0`, `kill1` and `flush`. Go to EXC_REDIR.
    - Else `trap1`: capture `epc=ex_pc1`, `cause_slot=1`. Assert `kill1` and `flush`; `kill0=0` (the older instruction completes). Go to EXC_REDIR.
    - `eret` is ignored in IDLE.
  - **EXC_REDIR**: `redirect_valid=1`, `redirect_pc=EXC_VECTOR`. On `redirect_ready`, go to IN_HANDLER.
  - **IN_HANDLER**: `eret` goes to RET_REDIR. Traps are masked: no kill, no capture.
  - **RET_REDIR**: `redirect_valid=1`, `redirect_pc=epc`. On `redirect_ready`, clear `exl` and go to IDLE.
- `redirect_pc` is 0 when `redirect_valid=0`.
- `exc_count` increments by 1 per capture and saturates at all-ones.
- Reset: asynchronous on `rst` falling, held while low.
  - State goes to IDLE.
  - `epc`, `cause_code`, `cause_slot`, `exl`, `exc_count`, `redirect_valid`, `redirect_pc`, `busy` all reset to 0.
  - `kill0`, `kill1`, `flush` are 0 because all their terms are gated by IDLE and valid.
- Reset mid-handshake abandons the redirect. No partial state survives.

## Timing
- Trap presented in cycle N gives `kill`/`flush` in cycle N (same cycle). EPC/cause update at edge N→N+1. `redirect_valid` is high from cycle N+1.
- Handshake completes at the first rising edge with `redirect_valid & redirect_ready`.
  - `redirect_valid` drops the next cycle.
  - `redirect_valid` stays high, with `redirect_pc` stable, until accepted. The minimum redirect is 1 cycle.
- `eret` in cycle M (IN_HANDLER) gives `redirect_valid` from M+1. `exl` clears and `busy` drops after acceptance.
- Simultaneous events:
  - Both slots trap: slot 0 wins and both slots are killed.
  - `eret` with traps in IN_HANDLER: `eret` is taken and traps are ignored.
  - `eret` in EXC_REDIR/RET_REDIR: ignored.
  - A trap in the same cycle as RET_REDIR acceptance: ignored. Trap capture resumes only the cycle after entering IDLE.
- `ex_ovfN` with `ex_trap_enN=0` or `ex_validN=0` never causes an action.

## Test plan
- Slot 0 trap only: `ex_pc0=0x100`, `ovf0=trap_en0=valid0=1`, `redirect_ready=1` at N+1. Expect `kill0=kill1=flush=1` in cycle N. At N+1: `redirect_pc=0x80`, `epc=0x100`, `cause_slot=0`, `cause_code=12`, `exl=1`, `exc_count=1`.
- Slot 1 only, with `ex_pc1=0x204`: expect `kill0=0`, `kill1=1` and `epc=0x204`, `cause_slot=1`. Both slots trapping instead gives `epc=ex_pc0` and `cause_slot=0`.
- Backpressure: `redirect_ready=0` for 5 cycles. Expect `redirect_valid` held with `redirect_pc=0x80` stable, then IN_HANDLER one cycle after ready. A trap injected during the wait gives no kill and no count change.
- Return: `eret` in IN_HANDLER and ready after 2 cycles. Expect `redirect_pc=0x100` and `exl`/`busy` cleared after acceptance. `eret` in IDLE does nothing.
- Masking/garbage: `ovf0=1` with `trap_en0=0`, and `ovf1=1` with `valid1=0`, in IDLE. Expect no outputs asserted.
- Reset during EXC_REDIR: all outputs 0 immediately, asynchronously.
- Counter saturation: force 2^CNT_W + 1 exceptions with CNT_W=4. Expect `exc_count` to stop at 15.

Source files
------------

// File: rtl/ovf_exception_unit.sv
// Overflow exception unit for the dual-issue EX stage: squashes faulting/younger slots,
// records EPC/cause and steers the front end to the handler and back on eret.
module ovf_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid0,
  input  logic             ex_valid1,
  input  logic             ex_ovf0,
  input  logic             ex_ovf1,
  input  logic             ex_trap_en0,
  input  logic             ex_trap_en1,
  input  logic [31:0]      ex_pc0,
  input  logic [31:0]      ex_pc1,
  input  logic             eret,
  input  logic             redirect_ready,
  output logic             kill0,
  output logic             kill1,
  output logic             flush,
  output logic             busy,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic [4:0]       cause_code,
  output logic             cause_slot,
  output logic             exl,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXC_REDIR  = 2'd1,
    IN_HANDLER = 2'd2,
    RET_REDIR  = 2'd3
  } state_t;

  localparam logic [4:0] CAUSE_OVF = 5'd12;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_trap0;
  logic             w_trap1;
  logic             w_capture;
  logic             w_ret_done;
  logic [31:0]      r_epc;
  logic [4:0]       r_cause_code;
  logic             r_cause_slot;
  logic             r_exl;
  logic [CNT_W-1:0] r_exc_count;

  // Overflow flags are garbage unless the slot is a real trapping add/sub.
  assign w_trap0 = ex_valid0 & ex_trap_en0 & ex_ovf0;
  assign w_trap1 = ex_valid1 & ex_trap_en1 & ex_ovf1;

  // NOTE: every output of this block is assigned a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_ret_done   = 1'b0;
    kill0        = 1'b0;
    kill1        = 1'b0;
    flush        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_trap0 | w_trap1) begin
          w_capture    = 1'b1;
          kill0        = w_trap0;
          kill1        = 1'b1;
          flush        = 1'b1;
          w_next_state = EXC_REDIR;
        end
      end
      EXC_REDIR: if (redirect_ready) w_next_state = IN_HANDLER;
      IN_HANDLER: if (eret) w_next_state = RET_REDIR;
      RET_REDIR: begin
        if (redirect_ready) begin
          w_ret_done   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_epc        <= '0;
      r_cause_code <= '0;
      r_cause_slot <= 1'b0;
      r_exl        <= 1'b0;
      r_exc_count  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_epc        <= w_trap0 ? ex_pc0 : ex_pc1;
        r_cause_slot <= ~w_trap0;
        r_cause_code <= CAUSE_OVF;
        r_exl        <= 1'b1;
        if (r_exc_count != {CNT_W{1'b1}}) r_exc_count <= r_exc_count + 1'b1;
      end else if (w_ret_done) begin
        r_exl <= 1'b0;
      end
    end
  end

  // Redirect is a pure decode of the state register, so it is held stable until accepted.
  assign redirect_valid = (r_state == EXC_REDIR) || (r_state == RET_REDIR);
  assign redirect_pc    = (r_state == EXC_REDIR) ? EXC_VECTOR :
                          (r_state == RET_REDIR) ? r_epc      : 32'h0;
  assign busy           = (r_state != IDLE);
  assign epc            = r_epc;
  assign cause_code     = r_cause_code;
  assign cause_slot     = r_cause_slot;
  assign exl            = r_exl;
  assign exc_count      = r_exc_count;

endmodule

// File: tb/tb_ovf_exception_unit.sv
// Directed bench for ovf_exception_unit; DUT built with CNT_W=4 so saturation is reachable.
module tb_ovf_exception_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ex_valid0, ex_valid1, ex_ovf0, ex_ovf1;
  logic             ex_trap_en0, ex_trap_en1;
  logic [31:0]      ex_pc0, ex_pc1;
  logic             eret, redirect_ready;
  logic             kill0, kill1, flush, busy, redirect_valid;
  logic [31:0]      redirect_pc, epc;
  logic [4:0]       cause_code;
  logic             cause_slot, exl;
  logic [CNT_W-1:0] exc_count;

  int n_checks = 0;
  int n_errors = 0;

  ovf_exception_unit #(.EXC_VECTOR(32'h0000_0080), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid0(ex_valid0), .ex_valid1(ex_valid1),
    .ex_ovf0(ex_ovf0), .ex_ovf1(ex_ovf1),
    .ex_trap_en0(ex_trap_en0), .ex_trap_en1(ex_trap_en1),
    .ex_pc0(ex_pc0), .ex_pc1(ex_pc1),
    .eret(eret), .redirect_ready(redirect_ready),
    .kill0(kill0), .kill1(kill1), .flush(flush), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .epc(epc), .cause_code(cause_code), .cause_slot(cause_slot),
    .exl(exl), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic quiet_inputs();
    ex_valid0 = 0; ex_valid1 = 0; ex_ovf0 = 0; ex_ovf1 = 0;
    ex_trap_en0 = 0; ex_trap_en1 = 0; ex_pc0 = '0; ex_pc1 = '0;
    eret = 0; redirect_ready = 0;
  endtask

  task automatic set_trap0(input logic [31:0] pc);
    ex_valid0 = 1; ex_trap_en0 = 1; ex_ovf0 = 1; ex_pc0 = pc;
  endtask

  task automatic set_trap1(input logic [31:0] pc);
    ex_valid1 = 1; ex_trap_en1 = 1; ex_ovf1 = 1; ex_pc1 = pc;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Full trap -> handler -> eret -> return round trip with immediate acceptance.
  task automatic round_trip(input logic [31:0] pc);
    set_trap0(pc); #1;
    next_cycle(); quiet_inputs(); redirect_ready = 1;
    next_cycle(); redirect_ready = 0; eret = 1;
    next_cycle(); eret = 0; redirect_ready = 1;
    next_cycle(); redirect_ready = 0;
  endtask

  initial begin
    quiet_inputs();
    #2;
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc",    redirect_pc,    0);
    check("rst_busy",           busy,           0);
    check("rst_epc",            epc,            0);
    check("rst_cause_code",     cause_code,     0);
    check("rst_exl",            exl,            0);
    check("rst_count",          exc_count,      0);
    check("rst_kill_flush",     {kill0, kill1, flush}, 0);
    next_cycle(); rst = 1;
    next_cycle();

    // Slot 0 trap.
    set_trap0(32'h100); #1;
    check("s0_kills_flush", {kill0, kill1, flush}, 3'b111);
    check("s0_busy_n",      busy, 0);
    next_cycle(); quiet_inputs(); redirect_ready = 1; #1;
    check("s0_rv",         redirect_valid, 1);
    check("s0_rpc",        redirect_pc, 32'h80);
    check("s0_epc",        epc, 32'h100);
    check("s0_slot",       cause_slot, 0);
    check("s0_cause",      cause_code, 12);
    check("s0_exl",        exl, 1);
    check("s0_count",      exc_count, 1);
    next_cycle(); redirect_ready = 0;
    check("hdl_rv",        redirect_valid, 0);
    check("hdl_rpc",       redirect_pc, 0);
    check("hdl_busy",      busy, 1);

    // Return with acceptance delayed by 2 cycles.
    eret = 1;
    next_cycle(); eret = 0;
    check("ret_rv",        redirect_valid, 1);
    check("ret_rpc",       redirect_pc, 32'h100);
    next_cycle();
    check("ret_hold_rpc",  redirect_pc, 32'h100);
    redirect_ready = 1;
    next_cycle(); redirect_ready = 0;
    check("ret_done_exl",  exl, 0);
    check("ret_done_busy", busy, 0);
    check("ret_done_rv",   redirect_valid, 0);

    // eret in IDLE is ignored.
    eret = 1;
    next_cycle(); eret = 0;
    check("idle_eret_busy", busy, 0);
    check("idle_eret_rv",   redirect_valid, 0);

    // Slot 1 only, then backpressure with traps and eret injected while waiting.
    ex_pc0 = 32'h200; set_trap1(32'h204); #1;
    check("s1_kill0", kill0, 0);
    check("s1_kill1", kill1, 1);
    check("s1_flush", flush, 1);
    next_cycle(); quiet_inputs();
    check("s1_epc",   epc, 32'h204);
    check("s1_slot",  cause_slot, 1);
    check("s1_count", exc_count, 2);
    for (int i = 0; i < 5; i++) begin
      set_trap0(32'h400); eret = (i == 2); #1;
      check("bp_rv",    redirect_valid, 1);
      check("bp_rpc",   redirect_pc, 32'h80);
      check("bp_kill",  {kill0, kill1, flush}, 0);
      next_cycle();
      check("bp_count", exc_count, 2);
    end
    quiet_inputs(); redirect_ready = 1;
    next_cycle(); redirect_ready = 0;
    check("bp_handler_rv",   redirect_valid, 0);
    check("bp_handler_busy", busy, 1);

    // Trap together with eret in IN_HANDLER: eret wins, trap masked.
    set_trap0(32'h500); eret = 1; #1;
    check("mask_kill", {kill0, kill1, flush}, 0);
    next_cycle(); eret = 0;
    check("mask_epc",  epc, 32'h204);
    check("mask_rpc",  redirect_pc, 32'h204);
    // Trap in the cycle RET_REDIR is accepted is ignored.
    redirect_ready = 1; #1;
    check("retacc_kill", {kill0, kill1, flush}, 0);
    next_cycle(); quiet_inputs();
    check("retacc_busy",  busy, 0);
    check("retacc_count", exc_count, 2);
    check("retacc_rv",    redirect_valid, 0);

    // Both slots trap: slot 0 wins.
    set_trap0(32'h300); set_trap1(32'h304); #1;
    check("both_kills", {kill0, kill1, flush}, 3'b111);
    next_cycle(); quiet_inputs(); redirect_ready = 1;
    check("both_epc",   epc, 32'h300);
    check("both_slot",  cause_slot, 0);
    check("both_count", exc_count, 3);
    next_cycle(); redirect_ready = 0; eret = 1;
    next_cycle(); eret = 0; redirect_ready = 1;
    next_cycle(); redirect_ready = 0;
    check("both_ret_busy", busy, 0);

    // Garbage overflow flags in IDLE.
    ex_valid0 = 1; ex_ovf0 = 1; ex_trap_en0 = 0;
    ex_valid1 = 0; ex_ovf1 = 1; ex_trap_en1 = 1; #1;
    check("garb_kill", {kill0, kill1, flush}, 0);
    next_cycle(); quiet_inputs();
    check("garb_busy",  busy, 0);
    check("garb_count", exc_count, 3);

    // Asynchronous reset in the middle of EXC_REDIR.
    set_trap0(32'h600); #1;
    next_cycle(); quiet_inputs();
    check("pre_rst_rv", redirect_valid, 1);
    #2; rst = 0; #1;
    check("arst_rv",    redirect_valid, 0);
    check("arst_rpc",   redirect_pc, 0);
    check("arst_busy",  busy, 0);
    check("arst_epc",   epc, 0);
    check("arst_cause", cause_code, 0);
    check("arst_slot",  cause_slot, 0);
    check("arst_exl",   exl, 0);
    check("arst_count", exc_count, 0);
    next_cycle(); rst = 1;
    next_cycle();

    // Saturation: 17 exceptions on a 4-bit counter.
    for (int i = 1; i <= 17; i++) begin
      round_trip(32'h1000 + i * 4);
      check("sat_count", exc_count, (i > 15) ? 15 : i);
    end
    check("sat_final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
